// File: rtl/bypass_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// bypass_scoreboard_pkg
// Shared constants for the decode-stage bypass network and register scoreboard.
//   BYPASS_STAGE_EXEC/MEM/WB : bypass stage indices, 0 = youngest
//   PREG_ZERO                : hard-wired zero physical register
// -----------------------------------------------------------------------------
package bypass_scoreboard_pkg;

    localparam int BYPASS_STAGE_EXEC = 0;
    localparam int BYPASS_STAGE_MEM  = 1;
    localparam int BYPASS_STAGE_WB   = 2;

    localparam int PREG_ZERO = 0;

endpackage : bypass_scoreboard_pkg

// File: rtl/bypass_port_mux.sv
// -----------------------------------------------------------------------------
// bypass_port_mux
// Operand select for one decode source port. Scans the bypass stages from
// youngest to oldest and takes the first stage writing the source register.
// Ports:
//   src_en, src_addr, src_rf_data : source request and register-file data
//   busy                          : scoreboard bit for src_addr
//   stg_wb/stg_ready/stg_addr/stg_data : per-stage write info
//   data                          : bypassed operand
//   hazard                        : operand not yet available, decode must hold
// -----------------------------------------------------------------------------
module bypass_port_mux
    import bypass_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 6,
    parameter int NUM_STAGES = 3,
    parameter int HARD_ZERO  = 1
) (
    input  logic                             src_en,
    input  logic [PREG_WIDTH-1:0]            src_addr,
    input  logic [DATA_WIDTH-1:0]            src_rf_data,
    input  logic                             busy,
    input  logic [NUM_STAGES-1:0]            stg_wb,
    input  logic [NUM_STAGES-1:0]            stg_ready,
    input  logic [NUM_STAGES*PREG_WIDTH-1:0] stg_addr,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] stg_data,
    output logic [DATA_WIDTH-1:0]            data,
    output logic                             hazard
);

    logic found;

    always_comb begin
        data   = src_rf_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (!found && stg_wb[k] && (stg_addr[k*PREG_WIDTH +: PREG_WIDTH] == src_addr)) begin
                found = 1'b1;
                if (stg_ready[k]) begin
                    data = stg_data[k*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    // Youngest producer is still computing; older stages hold stale values.
                    hazard = 1'b1;
                end
            end
        end
        if (!found && busy) begin
            hazard = 1'b1;
        end
        if (!src_en) begin
            data   = src_rf_data;
            hazard = 1'b0;
        end
        if ((HARD_ZERO != 0) && (src_addr == PREG_WIDTH'(PREG_ZERO))) begin
            data   = '0;
            hazard = 1'b0;
        end
    end

endmodule : bypass_port_mux

// File: rtl/bypass_scoreboard.sv
// -----------------------------------------------------------------------------
// bypass_scoreboard
// Decode-stage bypass network plus busy-bit scoreboard over physical registers.
// Each source port takes the youngest ready stage value; sources whose producer
// is in flight but not forwardable raise dec_stall.
// Ports:
//   clk, rst_n (synchronous, active low)
//   src_en/src_addr/src_rf_data -> src_data, dec_stall
//   issue_en/issue_addr         : sets busy (ignored while dec_stall)
//   stg_wb/stg_ready/stg_addr/stg_data : bypass stages, 0 = youngest
//   commit_en/commit_addr, kill_en/kill_addr : clear busy
//   perf_stall_cnt              : saturating stall-cycle count
// Optional: define BYPASS_STALL_CNT_EN to build the stall counter; otherwise
// perf_stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module bypass_scoreboard
    import bypass_scoreboard_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 6,
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 3,
    parameter int HARD_ZERO  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_READ-1:0]              src_en,
    input  logic [NUM_READ*PREG_WIDTH-1:0]   src_addr,
    input  logic [NUM_READ*DATA_WIDTH-1:0]   src_rf_data,
    output logic [NUM_READ*DATA_WIDTH-1:0]   src_data,
    output logic                             dec_stall,
    input  logic                             issue_en,
    input  logic [PREG_WIDTH-1:0]            issue_addr,
    input  logic [NUM_STAGES-1:0]            stg_wb,
    input  logic [NUM_STAGES-1:0]            stg_ready,
    input  logic [NUM_STAGES*PREG_WIDTH-1:0] stg_addr,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0] stg_data,
    input  logic                             commit_en,
    input  logic [PREG_WIDTH-1:0]            commit_addr,
    input  logic                             kill_en,
    input  logic [PREG_WIDTH-1:0]            kill_addr,
    output logic [31:0]                      perf_stall_cnt
);

    localparam int NUM_PREG = 2 ** PREG_WIDTH;

    logic [NUM_PREG-1:0] busy;
    logic [NUM_READ-1:0] hazard;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_port
        bypass_port_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .PREG_WIDTH (PREG_WIDTH),
            .NUM_STAGES (NUM_STAGES),
            .HARD_ZERO  (HARD_ZERO)
        ) u_mux (
            .src_en      (src_en[i]),
            .src_addr    (src_addr[i*PREG_WIDTH +: PREG_WIDTH]),
            .src_rf_data (src_rf_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .busy        (busy[src_addr[i*PREG_WIDTH +: PREG_WIDTH]]),
            .stg_wb      (stg_wb),
            .stg_ready   (stg_ready),
            .stg_addr    (stg_addr),
            .stg_data    (stg_data),
            .data        (src_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .hazard      (hazard[i])
        );
    end

    assign dec_stall = |hazard;

    // Later assignments win, so a same-cycle issue overrides commit/kill on one address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (commit_en) begin
                busy[commit_addr] <= 1'b0;
            end
            if (kill_en) begin
                busy[kill_addr] <= 1'b0;
            end
            if (issue_en && !dec_stall) begin
                busy[issue_addr] <= 1'b1;
            end
            if (HARD_ZERO != 0) begin
                busy[PREG_ZERO] <= 1'b0;
            end
        end
    end

`ifdef BYPASS_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (dec_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule : bypass_scoreboard
